// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack data/IO bus access with byte enables, load alignment and a bus timeout.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_ioRead,
  input  logic        in_ioWrite,
  input  logic        in_MemtoReg,
  input  logic        in_RegWrite,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_ALUResult,
  input  logic [31:0] in_rs2_v,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        WB_valid,
  output logic        WB_RegWrite,
  output logic        WB_MemtoReg,
  output logic [4:0]  WB_rd_addr,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_load_data,
  output logic        WB_buserr,
  output logic        WB_misalign
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       memop, is_read, is_write, misalign;
  logic       pass, trap, issue, done, abort;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] v);
    case (f3[1:0])
      2'b00:   return {4{v[7:0]}};
      2'b01:   return {2{v[15:0]}};
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign is_read  = in_MemRead | in_ioRead;
  assign is_write = in_MemWrite | in_ioWrite;
  assign memop    = in_valid & (is_read | is_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = ((in_funct3[1:0] == 2'b01) & in_ALUResult[0]) |
                    (in_funct3[1] & (in_ALUResult[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ack takes priority over the timeout when both land in the same cycle
  always_comb begin
    state_nxt = state;
    pass      = 1'b0;
    trap      = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (!memop)        pass = 1'b1;
        else if (misalign) trap = 1'b1;
        else begin
          issue     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == LIMIT) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = memop & ~trap & ~done & ~abort;

  // MEM/WB register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      WB_valid     <= 1'b0;
      WB_RegWrite  <= 1'b0;
      WB_MemtoReg  <= 1'b0;
      WB_rd_addr   <= '0;
      WB_ALUResult <= '0;
      WB_load_data <= '0;
      WB_buserr    <= 1'b0;
      WB_misalign  <= 1'b0;
    end else begin
      WB_buserr   <= 1'b0;
      WB_misalign <= 1'b0;
      if (pass || trap) begin
        WB_valid     <= pass ? in_valid : 1'b1;
        WB_RegWrite  <= pass ? in_RegWrite : 1'b0;
        WB_MemtoReg  <= in_MemtoReg;
        WB_rd_addr   <= in_rd_addr;
        WB_ALUResult <= in_ALUResult;
        WB_load_data <= '0;
        WB_misalign  <= trap;
      end else if (issue) begin
        cnt        <= '0;
        dmem_req   <= 1'b1;
        dmem_we    <= is_write;
        dmem_addr  <= {in_ALUResult[31:2], 2'b00};
        dmem_be    <= is_write ? store_be(in_funct3, in_ALUResult[1:0]) : 4'b1111;
        dmem_wdata <= store_data(in_funct3, in_rs2_v);
        WB_valid   <= 1'b0;
      end else if (done || abort) begin
        dmem_req     <= 1'b0;
        WB_valid     <= 1'b1;
        WB_RegWrite  <= done ? in_RegWrite : 1'b0;
        WB_MemtoReg  <= in_MemtoReg;
        WB_rd_addr   <= in_rd_addr;
        WB_ALUResult <= in_ALUResult;
        WB_load_data <= (done && is_read) ?
                        load_align(in_funct3, in_ALUResult[1:0], dmem_rdata) : '0;
        WB_buserr    <= abort;
      end else begin
        cnt      <= cnt + 8'd1;
        WB_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops vs a behavioural model.
module tb_mem_access_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_MemRead, in_MemWrite, in_ioRead, in_ioWrite, in_MemtoReg, in_RegWrite;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_ALUResult, in_rs2_v;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        WB_valid, WB_RegWrite, WB_MemtoReg, WB_buserr, WB_misalign;
  logic [4:0]  WB_rd_addr;
  logic [31:0] WB_ALUResult, WB_load_data;

  int n_chk;
  int n_err;
  logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  mem_access_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_ioRead(in_ioRead), .in_ioWrite(in_ioWrite), .in_MemtoReg(in_MemtoReg),
    .in_RegWrite(in_RegWrite), .in_funct3(in_funct3), .in_rd_addr(in_rd_addr),
    .in_ALUResult(in_ALUResult), .in_rs2_v(in_rs2_v), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .WB_valid(WB_valid), .WB_RegWrite(WB_RegWrite),
    .WB_MemtoReg(WB_MemtoReg), .WB_rd_addr(WB_rd_addr), .WB_ALUResult(WB_ALUResult),
    .WB_load_data(WB_load_data), .WB_buserr(WB_buserr), .WB_misalign(WB_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Reference model: plain arithmetic over the access-size rules
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> ((a % 4) * 8)) & 32'hFF;
    h = (w >> ((a & 32'd2) * 8)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (!wr) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << (a % 4));
    if (f3 == 3'd1) return 4'(3 << (a & 32'd2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] v);
    if (f3 == 3'd0) return (v & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (v & 32'hFFFF) * 32'h0001_0001;
    return v;
  endfunction

  task automatic clear_inputs();
    in_valid = 0; in_MemRead = 0; in_MemWrite = 0; in_ioRead = 0; in_ioWrite = 0;
    in_MemtoReg = 0; in_RegWrite = 0; in_funct3 = 0; in_rd_addr = 0; in_ALUResult = 0;
    in_rs2_v = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Drives one memory op; ack_at = BUSY cycle carrying ack (0 = never)
  task automatic mem_op(input string tag, input logic wr, input logic io, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic m2r, input int ack_at, input logic [31:0] rdata,
                        output logic [31:0] got, output int stalls);
    logic fin, tmo, est;
    fin = 0; tmo = 0; stalls = 0;
    in_valid = 1; in_MemRead = ~wr & ~io; in_ioRead = ~wr & io;
    in_MemWrite = wr & ~io; in_ioWrite = wr & io; in_funct3 = f3; in_rd_addr = rd;
    in_ALUResult = a; in_rs2_v = rs2; in_RegWrite = rw; in_MemtoReg = m2r; dmem_ack = 0;
    #1;
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL %s stall_issue: got %b want 1", tag, stall); end
    if (stall === 1'b1) stalls++;
    @(posedge clk); #1;
    n_chk++; if (dmem_req !== 1'b1 || dmem_we !== wr) begin n_err++; $display("FAIL %s req_we: got %b%b want 1%b", tag, dmem_req, dmem_we, wr); end
    n_chk++; if (dmem_addr !== (a & 32'hFFFF_FFFC)) begin n_err++; $display("FAIL %s addr: got %h want %h", tag, dmem_addr, a & 32'hFFFF_FFFC); end
    n_chk++; if (dmem_be !== exp_be(wr, f3, a)) begin n_err++; $display("FAIL %s be: got %b want %b", tag, dmem_be, exp_be(wr, f3, a)); end
    if (wr) begin
      n_chk++; if (dmem_wdata !== exp_wd(f3, rs2)) begin n_err++; $display("FAIL %s wdata: got %h want %h", tag, dmem_wdata, exp_wd(f3, rs2)); end
    end
    n_chk++; if (WB_valid !== 1'b0) begin n_err++; $display("FAIL %s wb_valid_issue: got %b want 0", tag, WB_valid); end
    for (int i = 1; i <= TMO && !fin; i++) begin
      dmem_ack = (i == ack_at);
      dmem_rdata = (i == ack_at) ? rdata : $urandom();
      tmo = (i == TMO) && (i != ack_at);
      fin = (i == ack_at) || tmo;
      est = ~fin;
      #1;
      n_chk++; if (stall !== est) begin n_err++; $display("FAIL %s stall_busy%0d: got %b want %b", tag, i, stall, est); end
      if (stall === 1'b1) stalls++;
      @(posedge clk); #1;
      dmem_ack = 0;
      if (!fin) begin
        n_chk++; if (dmem_req !== 1'b1 || WB_valid !== 1'b0 || dmem_addr !== (a & 32'hFFFF_FFFC)) begin n_err++; $display("FAIL %s hold%0d: got req=%b wbv=%b addr=%h want 1 0 %h", tag, i, dmem_req, WB_valid, dmem_addr, a & 32'hFFFF_FFFC); end
      end
    end
    n_chk++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL %s req_drop: got %b want 0", tag, dmem_req); end
    n_chk++; if (WB_valid !== 1'b1 || WB_buserr !== tmo || WB_misalign !== 1'b0) begin n_err++; $display("FAIL %s wb_flags: got v=%b be=%b ma=%b want 1 %b 0", tag, WB_valid, WB_buserr, WB_misalign, tmo); end
    n_chk++; if (WB_RegWrite !== (tmo ? 1'b0 : rw)) begin n_err++; $display("FAIL %s regwrite: got %b want %b", tag, WB_RegWrite, tmo ? 1'b0 : rw); end
    n_chk++; if (WB_rd_addr !== rd || WB_ALUResult !== a || WB_MemtoReg !== m2r) begin n_err++; $display("FAIL %s wb_fields: got %h %h %b want %h %h %b", tag, WB_rd_addr, WB_ALUResult, WB_MemtoReg, rd, a, m2r); end
    if (!tmo && !wr) begin
      n_chk++; if (WB_load_data !== exp_load(f3, a, rdata)) begin n_err++; $display("FAIL %s load_data: got %h want %h", tag, WB_load_data, exp_load(f3, a, rdata)); end
    end
    got = WB_load_data;
    clear_inputs();
    @(posedge clk); #1;
    n_chk++; if (WB_valid !== 1'b0 || WB_buserr !== 1'b0) begin n_err++; $display("FAIL %s pulse_end: got v=%b be=%b want 0 0", tag, WB_valid, WB_buserr); end
  endtask

  task automatic alu_op(input string tag, input logic v, input logic [31:0] r, input logic [4:0] rd,
                        input logic rw, input logic m2r, input logic ack);
    in_valid = v; in_MemRead = 0; in_MemWrite = 0; in_ioRead = 0; in_ioWrite = 0;
    in_ALUResult = r; in_rd_addr = rd; in_RegWrite = rw; in_MemtoReg = m2r;
    dmem_ack = ack; dmem_rdata = $urandom();
    #1;
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL %s stall: got %b want 0", tag, stall); end
    @(posedge clk); #1;
    n_chk++; if (WB_valid !== v || WB_ALUResult !== r || WB_rd_addr !== rd || WB_RegWrite !== rw || WB_MemtoReg !== m2r) begin n_err++; $display("FAIL %s wb: got %b %h %h %b %b want %b %h %h %b %b", tag, WB_valid, WB_ALUResult, WB_rd_addr, WB_RegWrite, WB_MemtoReg, v, r, rd, rw, m2r); end
    n_chk++; if (WB_load_data !== 32'd0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL %s ld_req: got %h %b want 0 0", tag, WB_load_data, dmem_req); end
    dmem_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, WB_valid, WB_RegWrite, WB_MemtoReg, WB_rd_addr, WB_ALUResult, WB_load_data, WB_buserr, WB_misalign, stall} !== '0) begin n_err++; $display("FAIL reset_outputs: got nonzero req=%b addr=%h wbv=%b want all 0", dmem_req, dmem_addr, WB_valid); end
    rst = 0;
  endtask

  task automatic test_lw_wait();
    logic [31:0] got; int st;
    mem_op("lw_wait", 0, 0, 3'b010, 32'h100, 0, 5'd4, 1, 1, 3, 32'h1234_5678, got, st);
    n_chk++; if (st != 3) begin n_err++; $display("FAIL lw_wait stall_cycles: got %0d want 3", st); end
    n_chk++; if (got !== 32'h1234_5678) begin n_err++; $display("FAIL lw_wait data: got %h want 12345678", got); end
  endtask

  task automatic test_store_byte();
    logic [31:0] got; int st;
    mem_op("sb", 1, 0, 3'b000, 32'h203, 32'hAB, 5'd0, 0, 0, 1, 32'h0, got, st);
    n_chk++; if (st != 1) begin n_err++; $display("FAIL sb stall_cycles: got %0d want 1", st); end
    mem_op("sh_io", 1, 1, 3'b001, 32'h402, 32'h1234_BEEF, 5'd0, 0, 0, 2, 32'h0, got, st);
    mem_op("sw", 1, 0, 3'b010, 32'h40C, 32'hCAFE_F00D, 5'd0, 0, 0, 1, 32'h0, got, st);
  endtask

  task automatic test_load_ext();
    logic [31:0] got; int st;
    mem_op("lb", 0, 0, 3'b000, 32'h2, 0, 5'd3, 1, 1, 1, 32'h0080_FF00, got, st);
    n_chk++; if (got !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb value: got %h want ffffff80", got); end
    mem_op("lbu", 0, 0, 3'b100, 32'h2, 0, 5'd3, 1, 1, 2, 32'h0080_FF00, got, st);
    n_chk++; if (got !== 32'h0000_0080) begin n_err++; $display("FAIL lbu value: got %h want 00000080", got); end
    mem_op("lhu", 0, 0, 3'b101, 32'h2, 0, 5'd5, 1, 1, 1, 32'h8001_0000, got, st);
    n_chk++; if (got !== 32'h0000_8001) begin n_err++; $display("FAIL lhu value: got %h want 00008001", got); end
    mem_op("lh_io", 0, 1, 3'b001, 32'h2, 0, 5'd5, 1, 1, 1, 32'h8001_0000, got, st);
    n_chk++; if (got !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_io value: got %h want ffff8001", got); end
  endtask

  task automatic test_alu_b2b();
    alu_op("add", 1, 32'h55, 5'd9, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      alu_op("b2b", 1'($urandom()), $urandom(), 5'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
    clear_inputs();
  endtask

  task automatic test_timeout();
    logic [31:0] got; int st;
    mem_op("lw_tmo", 0, 0, 3'b010, 32'h180, 0, 5'd6, 1, 1, 0, 32'h0, got, st);
    n_chk++; if (st != TMO) begin n_err++; $display("FAIL lw_tmo stall_cycles: got %0d want %0d", st, TMO); end
    mem_op("ack_at_limit", 0, 0, 3'b010, 32'h184, 0, 5'd6, 1, 1, TMO, 32'h5A5A_0F0F, got, st);
    // reset while a request is pending
    in_valid = 1; in_MemRead = 1; in_funct3 = 3'b010; in_ALUResult = 32'h3C4; in_rd_addr = 5'd7; in_RegWrite = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rst_busy pending: got %b want 1", dmem_req); end
    rst = 1; clear_inputs();
    @(posedge clk); #1;
    n_chk++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, WB_valid, WB_RegWrite, WB_MemtoReg, WB_rd_addr, WB_ALUResult, WB_load_data, WB_buserr, WB_misalign, stall} !== '0) begin n_err++; $display("FAIL rst_busy outputs: got req=%b addr=%h be=%b want all 0", dmem_req, dmem_addr, dmem_be); end
    rst = 0; dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 0;
    n_chk++; if (dmem_req !== 1'b0 || WB_valid !== 1'b0 || WB_load_data !== 32'd0) begin n_err++; $display("FAIL idle_ack ignored: got %b %b %h want 0 0 0", dmem_req, WB_valid, WB_load_data); end
  endtask

  task automatic test_misalign();
    logic [31:0] got; int st;
`ifdef MEM_MISALIGN_TRAP_EN
    in_valid = 1; in_MemRead = 1; in_funct3 = 3'b010; in_ALUResult = 32'h102; in_rd_addr = 5'd8; in_RegWrite = 1;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL trap stall: got %b want 0", stall); end
    @(posedge clk); #1;
    n_chk++; if (dmem_req !== 1'b0 || WB_misalign !== 1'b1 || WB_valid !== 1'b1 || WB_RegWrite !== 1'b0) begin n_err++; $display("FAIL trap wb: got req=%b ma=%b v=%b rw=%b want 0 1 1 0", dmem_req, WB_misalign, WB_valid, WB_RegWrite); end
    clear_inputs();
    @(posedge clk); #1;
    n_chk++; if (WB_misalign !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL trap pulse_end: got ma=%b req=%b want 0 0", WB_misalign, dmem_req); end
    got = 0; st = 0;
`else
    mem_op("lw_unaligned", 0, 0, 3'b010, 32'h102, 0, 5'd8, 1, 1, 1, 32'hDEAD_BEEF, got, st);
    n_chk++; if (got !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_unaligned value: got %h want deadbeef", got); end
    mem_op("lh_odd", 0, 0, 3'b001, 32'h101, 0, 5'd8, 1, 1, 2, 32'h1234_ABCD, got, st);
    n_chk++; if (got !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL lh_odd value: got %h want ffffabcd", got); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] got, a;
    logic [2:0]  f3;
    int st, kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom();
      f3 = (kind == 2) ? st_f3[$urandom_range(0, 5)] : 3'($urandom());
`ifdef MEM_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1]) a[1:0] = 2'b00;
`endif
      if (kind == 0)
        alu_op("rnd_alu", 1, a, 5'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
      else
        mem_op("rnd_mem", kind == 2, 1'($urandom()), f3, a, $urandom(), 5'($urandom()),
               1'($urandom()), 1'($urandom()), $urandom_range(0, TMO), $urandom(), got, st);
    end
    clear_inputs();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clear_inputs();
    test_reset();
    test_lw_wait();
    test_store_byte();
    test_load_ext();
    test_alu_b2b();
    test_timeout();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
